// File: rtl/fft_req_scheduler.sv
// Two-channel frame scheduler in front of a shared variable-size FFT core.
// A round-robin arbiter picks a requester and latches its configuration.
// The scheduler then streams exactly N samples from that requester into the core.
// Output beats from the core are tagged with the owning channel and bin index.
// The frame ends with a done pulse, or with an err pulse on a timeout or a beat-count mismatch.
module fft_req_scheduler #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       cfg0_sel,
  input  logic [1:0]       cfg1_sel,
  input  logic [2:0]       cfg0_lsn,
  input  logic [2:0]       cfg1_lsn,
  input  logic             cfg0_form,
  input  logic             cfg1_form,
  input  logic [WIDTH-1:0] din0_re,
  input  logic [WIDTH-1:0] din0_im,
  input  logic [WIDTH-1:0] din1_re,
  input  logic [WIDTH-1:0] din1_im,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             busy,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  output logic [1:0]       fft_sel,
  output logic [2:0]       fft_lsn,
  output logic             fft_form,
  input  logic             fft_ready,
  input  logic             fft_success,
  input  logic             fft_do_en,
  output logic             out_valid,
  output logic             out_ch,
  output logic [6:0]       out_idx
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic          cur_ch, last_ch, win_ch;
  logic          start, err_set, beats_match;
  logic          in_load, in_wait;
  logic [6:0]    n_minus1, sample_cnt;
  logic [7:0]    beat_cnt, beat_total;
  logic [TW-1:0] timer;
  logic [1:0]    win_sel;

  function automatic logic [6:0] last_index(input logic [1:0] sel);
    case (sel)
      2'b00:   return 7'd15;
      2'b01:   return 7'd63;
      2'b10:   return 7'd127;
      default: return 7'd31;
    endcase
  endfunction

  assign start       = (state == S_IDLE) && fft_ready && (req0 || req1);
  assign win_ch      = (req0 && req1) ? ~last_ch : req1;
  assign win_sel     = win_ch ? cfg1_sel : cfg0_sel;
  assign beat_total  = beat_cnt + {7'd0, fft_do_en};
  assign beats_match = (beat_total == ({1'b0, n_minus1} + 8'd1));
  assign in_load     = (state == S_LOAD);
  assign in_wait     = (state == S_WAIT);

  // State register; reset abandons any frame in flight without done or err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; err_set flags a timeout or a wrong number of output beats.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_CFG;
      S_CFG:  state_next = S_LOAD;
      S_LOAD: if (sample_cnt == n_minus1) state_next = S_WAIT;
      S_WAIT: begin
        if (fft_success) begin
          if (beats_match) begin
            state_next = S_DONE;
          end else begin
            state_next = S_IDLE;
            err_set    = 1'b1;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_next = S_IDLE;
          err_set    = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Latch the winner and its configuration at frame start; core config holds until the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_ch   <= 1'b0;
      last_ch  <= 1'b1;
      fft_sel  <= 2'b00;
      fft_lsn  <= 3'd0;
      fft_form <= 1'b0;
      n_minus1 <= 7'd0;
    end else if (start) begin
      cur_ch   <= win_ch;
      last_ch  <= win_ch;
      fft_sel  <= win_sel;
      fft_lsn  <= win_ch ? cfg1_lsn : cfg0_lsn;
      fft_form <= win_ch ? cfg1_form : cfg0_form;
      n_minus1 <= last_index(win_sel);
    end
  end

  // Sample, beat and timeout counters plus the registered err pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_cnt <= 7'd0;
      beat_cnt   <= 8'd0;
      timer      <= '0;
      err        <= 1'b0;
    end else begin
      sample_cnt <= in_load ? sample_cnt + 7'd1 : 7'd0;
      if (in_wait) begin
        timer <= timer + TW'(1);
        if (fft_do_en) beat_cnt <= beat_cnt + 8'd1;
      end else begin
        timer    <= '0;
        beat_cnt <= 8'd0;
      end
      err <= err_set;
    end
  end

  assign busy      = (state != S_IDLE);
  assign gnt0      = in_load && !cur_ch;
  assign gnt1      = in_load && cur_ch;
  assign fft_di_en = in_load;
  assign fft_di_re = in_load ? (cur_ch ? din1_re : din0_re) : '0;
  assign fft_di_im = in_load ? (cur_ch ? din1_im : din0_im) : '0;
  assign out_valid = in_wait && fft_do_en;
  assign out_ch    = in_wait && cur_ch;
  assign out_idx   = in_wait ? beat_cnt[6:0] : 7'd0;
  assign done0     = (state == S_DONE) && !cur_ch;
  assign done1     = (state == S_DONE) && cur_ch;

endmodule

// File: tb/tb_fft_req_scheduler.sv
// Randomized self-checking bench for fft_req_scheduler.
// The reference model tracks which channel was served last.
// From that it derives the expected winner, frame length, grant window, tagged beats and end-of-frame pulse.
module tb_fft_req_scheduler;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 512;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [1:0]       cfg0_sel, cfg1_sel;
  logic [2:0]       cfg0_lsn, cfg1_lsn;
  logic             cfg0_form, cfg1_form;
  logic [WIDTH-1:0] din0_re, din0_im, din1_re, din1_im;
  logic             gnt0, gnt1, done0, done1, err, busy;
  logic             fft_di_en;
  logic [WIDTH-1:0] fft_di_re, fft_di_im;
  logic [1:0]       fft_sel;
  logic [2:0]       fft_lsn;
  logic             fft_form;
  logic             fft_ready, fft_success, fft_do_en;
  logic             out_valid, out_ch;
  logic [6:0]       out_idx;

  int   vector_count     = 0;
  int   miscompare_count = 0;
  logic last_ch_model;

  fft_req_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .cfg0_sel(cfg0_sel), .cfg1_sel(cfg1_sel),
    .cfg0_lsn(cfg0_lsn), .cfg1_lsn(cfg1_lsn),
    .cfg0_form(cfg0_form), .cfg1_form(cfg1_form),
    .din0_re(din0_re), .din0_im(din0_im), .din1_re(din1_re), .din1_im(din1_im),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .busy(busy),
    .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_sel(fft_sel), .fft_lsn(fft_lsn), .fft_form(fft_form),
    .fft_ready(fft_ready), .fft_success(fft_success), .fft_do_en(fft_do_en),
    .out_valid(out_valid), .out_ch(out_ch), .out_idx(out_idx)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Run-time guard so a stuck design still ends the run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pointsOf(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16;
      2'b01:   return 64;
      2'b10:   return 128;
      default: return 32;
    endcase
  endfunction

  task automatic randomizeInputs();
    din0_re   = WIDTH'($urandom);
    din0_im   = WIDTH'($urandom);
    din1_re   = WIDTH'($urandom);
    din1_im   = WIDTH'($urandom);
    cfg0_sel  = 2'($urandom);
    cfg1_sel  = 2'($urandom);
    cfg0_lsn  = 3'($urandom);
    cfg1_lsn  = 3'($urandom);
    cfg0_form = 1'($urandom);
    cfg1_form = 1'($urandom);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_di_en"}, fft_di_en, 0);
    checkOutput({tag, "_di_re"}, fft_di_re, 0);
    checkOutput({tag, "_cfg"}, {26'd0, fft_sel, fft_lsn, fft_form}, 32'd0);
    checkOutput({tag, "_pulses"}, {29'd0, err, done1, done0}, 32'd0);
    checkOutput({tag, "_out"}, {23'd0, out_valid, out_ch, out_idx}, 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    #1 checkIdleOutputs("rst");
    @(negedge clock);
    reset = 1'b0;
    last_ch_model = 1'b1;
    #1;
  endtask

  // One full frame from an IDLE negedge with requests already set; mode 0=normal, 1=timeout, 2=short beats.
  task automatic applyStimulus(input int mode, input bit hold);
    logic             w;
    logic [1:0]       s;
    logic [2:0]       l;
    logic             f;
    logic [WIDTH-1:0] dre, dim;
    int               n, beats, target, gap;
    logic             en;
    w = (req0 && req1) ? ~last_ch_model : req1;
    s = w ? cfg1_sel : cfg0_sel;
    l = w ? cfg1_lsn : cfg0_lsn;
    f = w ? cfg1_form : cfg0_form;
    n = pointsOf(s);
    last_ch_model = w;
    #1 checkOutput("idle_busy", busy, 0);
    @(negedge clock);
    #1;
    checkOutput("cfg_busy", busy, 1);
    checkOutput("cfg_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    checkOutput("cfg_core", {26'd0, fft_sel, fft_lsn, fft_form}, {26'd0, s, l, f});
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      randomizeInputs();
      fft_do_en = 1'($urandom);
      dre = w ? din1_re : din0_re;
      dim = w ? din1_im : din0_im;
      #1;
      checkOutput("load_gnt", {30'd0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
      checkOutput("load_di", {fft_di_en, fft_di_re, fft_di_im}, {1'b1, dre, dim});
      checkOutput("load_out_valid", out_valid, 0);
      checkOutput("load_cfg_hold", {26'd0, fft_sel, fft_lsn, fft_form}, {26'd0, s, l, f});
    end
    @(negedge clock);
    fft_do_en = 1'b0;
    if (mode == 1) begin
      for (int t = 0; t < TIMEOUT; t++) begin
        #1;
        checkOutput("wait_gnt", {30'd0, gnt1, gnt0, fft_di_en}, 32'd0);
        checkOutput("wait_err_early", {err, busy}, 2'b01);
        @(negedge clock);
      end
      #1;
      checkOutput("timeout_err", err, 1);
      checkOutput("timeout_idle", busy, 0);
      checkOutput("timeout_done", {done1, done0}, 0);
      if (!hold) begin
        if (w) req1 = 1'b0; else req0 = 1'b0;
      end
    end else begin
      target = (mode == 2) ? n - 1 : n;
      beats  = 0;
      gap    = 0;
      for (int k = 0; beats < target && k < 1000; k++) begin
        en = ($urandom_range(0, 3) != 0) || (gap >= 2);
        fft_do_en = en;
        #1;
        checkOutput("wait_gnt", {30'd0, gnt1, gnt0, fft_di_en}, 32'd0);
        checkOutput("wait_out_valid", out_valid, en);
        if (en) begin
          checkOutput("beat_tag", {out_ch, out_idx}, {w, 7'(beats)});
          beats++;
          gap = 0;
        end else begin
          gap++;
        end
        @(negedge clock);
      end
      fft_do_en   = 1'b0;
      fft_success = 1'b1;
      #1 checkOutput("success_busy", busy, 1);
      @(negedge clock);
      fft_success = 1'b0;
      #1;
      if (mode == 2) begin
        checkOutput("short_err", err, 1);
        checkOutput("short_done", {done1, done0}, 0);
        checkOutput("short_idle", busy, 0);
        if (!hold) begin
          if (w) req1 = 1'b0; else req0 = 1'b0;
        end
      end else begin
        checkOutput("done_pulse", {err, done1, done0}, w ? 32'd2 : 32'd1);
        if (!hold) begin
          if (w) req1 = 1'b0; else req0 = 1'b0;
        end
        @(negedge clock);
        #1;
        checkOutput("done_clear", {err, done1, done0}, 0);
        checkOutput("done_idle", busy, 0);
      end
    end
  endtask

  // Directed scenarios followed by randomized frames and a mid-frame reset.
  initial begin
    int r, m;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    fft_ready = 1'b1; fft_success = 1'b0; fft_do_en = 1'b0;
    randomizeInputs();
    last_ch_model = 1'b1;
    repeat (2) @(negedge clock);
    #1 checkIdleOutputs("init");
    reset = 1'b0;
    @(negedge clock);

    cfg0_sel = 2'b00; cfg0_lsn = 3'd0; cfg0_form = 1'b0;
    req0 = 1'b1;
    applyStimulus(0, 1'b0);

    pulseReset();
    cfg0_sel = 2'b11; cfg1_sel = 2'b01;
    req0 = 1'b1; req1 = 1'b1;
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);

    req0 = 1'b1; req1 = 1'b1;
    repeat (4) applyStimulus(0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;

    cfg1_sel = 2'b10; req1 = 1'b1;
    applyStimulus(1, 1'b0);

    cfg0_sel = 2'b11; req0 = 1'b1;
    applyStimulus(2, 1'b0);

    fft_ready = 1'b0; req1 = 1'b1;
    repeat (3) begin
      @(negedge clock);
      #1 checkOutput("not_ready_busy", busy, 0);
    end
    fft_ready = 1'b1;
    applyStimulus(0, 1'b0);

    repeat (8) begin
      r = $urandom_range(1, 3);
      m = $urandom_range(0, 6);
      req0 = r[0]; req1 = r[1];
      applyStimulus((m < 5) ? 0 : m - 4, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;

    cfg0_sel = 2'b10; req0 = 1'b1;
    @(negedge clock);
    #1 checkOutput("mid_cfg_busy", busy, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      randomizeInputs();
      #1 checkOutput("mid_load_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    end
    #1 reset = 1'b1;
    #1 checkIdleOutputs("mid_rst");
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    last_ch_model = 1'b1;
    cfg1_sel = 2'($urandom);
    req1 = 1'b1;
    applyStimulus(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/fft_req_scheduler.md
Name: fft_req_scheduler

Overview:
- Frame scheduler that shares one alterable-point FFT core (16/32/64/128 points) between two requesters, ch0 and ch1.
- Arbitrates between the requesters round-robin and latches the winner's point/shift/format configuration.
- Streams exactly N contiguous samples into the core, then waits for the core's completion strobe.
- Tags every output beat with the owning channel and bin index, then signals done or timeout error.
- Sits between the sample producers and the FFT core.

Parameters:
- WIDTH, 16, sample width (re/im).
- TIMEOUT, 1024, max cycles in WAIT before declaring error.

Ports:
- clock  in  1  master clock
- reset  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  level request for one transform; held until doneN or err
- cfg0_sel / cfg1_sel  in  2  point select: 00=16, 01=64, 10=128, 11=32
- cfg0_lsn / cfg1_lsn  in  3  input left-shift number
- cfg0_form / cfg1_form  in  1  output format: 1=sign-magnitude, 0=two's complement
- din0_re, din0_im / din1_re, din1_im  in  WIDTH  requester sample buses
- gnt0 / gnt1  out  1  high during LOAD; requester must present a new sample every cycle gnt is high
- done0 / done1  out  1  1-cycle pulse when the channel's frame has fully emerged
- err  out  1  1-cycle pulse on WAIT timeout or beat-count mismatch
- busy  out  1  high in any state other than IDLE
- fft_di_en  out  1  core input enable
- fft_di_re, fft_di_im  out  WIDTH  core input data
- fft_sel  out  2  core point select
- fft_lsn  out  3  core left-shift number
- fft_form  out  1  core output format
- fft_ready  in  1  core can accept a frame
- fft_success  in  1  core signals its last output beat has been emitted
- fft_do_en  in  1  core output beat valid
- out_valid  out  1  copy of fft_do_en while in WAIT
- out_ch  out  1  owning channel of the current output beat
- out_idx  out  7  output beat index, 0..N-1

Behaviour:
- Reset (async): state=IDLE, last_ch=1 (so ch0 wins the first tie). All outputs 0, except fft_sel/lsn/form=0.
- Reset mid-frame aborts immediately: no done, no err. Requesters re-request after reset.
- State machine:
  - IDLE -> CFG when fft_ready=1 and (req0|req1).
    - Winner: the sole requester; if both request, the channel != last_ch.
    - Latch cur_ch, sel, lsn, form, N. last_ch <= winner.
  - CFG: one cycle. fft_sel/lsn/form are driven from latched values and remain stable until the next CFG. No gnt.
  - LOAD: exactly N cycles.
    - gnt[cur_ch]=1; fft_di_en=1; fft_di_re/im = din[cur_ch] (combinational mux, gated to 0 outside LOAD).
    - 7-bit sample counter; on count N-1 -> WAIT.
    - req deassertion during LOAD is ignored: the frame completes.
  - WAIT:
    - out_valid=fft_do_en; out_ch=cur_ch; out_idx=beat counter (increments per fft_do_en, starts 0).
    - On fft_success: if beat count == N -> DONE, else err pulse -> IDLE.
    - Timeout counter reaching TIMEOUT-1 -> err pulse, IDLE.
  - DONE: done[cur_ch] pulse for one cycle -> IDLE.
- fft_do_en outside WAIT is ignored (out_valid stays 0).
- Latency:
  - req at edge k (IDLE) -> CFG at k+1 -> gnt/fft_di_en first high at k+2.
  - Last input at k+1+N.
- Back-to-back: earliest next CFG is 1 cycle after DONE, provided fft_ready=1.
- Config inputs change outside CFG-entry have no effect on the frame in flight.

Test Plan:
- ch0 only, sel=00, lsn=0, impulse (1,0) then 15 zeros -> gnt0 high 16 cycles starting 2 cycles after req0; 16 out_valid beats with out_ch=0, idx 0..15; done0 pulse once.
- Both req same cycle after reset, ch0 sel=11, ch1 sel=01 -> ch0 served first (32 loads), then ch1 (64 loads); outputs tagged 0 then 1.
- req0 and req1 held continuously, 4 frames -> grant order 0,1,0,1; no channel served twice consecutively.
- ch1 sel=10, fft_success withheld by core model -> err pulse exactly TIMEOUT cycles after WAIT entry; state IDLE; no done1.
- Core model emits fft_success after 31 beats for sel=11 -> err pulse, no done0.
- Assert reset during LOAD (sample 40 of 128) -> all outputs 0 immediately; after release, req1 served from scratch with correct 2-cycle grant latency.
